// File: rtl/cmd_proto_pkg.sv
// rtl/cmd_proto_pkg.sv - shared command byte protocol constants and encoder state type
package cmd_proto_pkg;

  localparam int TYPE_W = 4;
  localparam int OP_W   = 5;
  localparam int SRC_W  = 16;

  localparam logic [7:0] END_BYTE_VAL = 8'hBD;

  // Fixed header positions; everything after IDX_END is padding.
  localparam int IDX_TYPE    = 0;
  localparam int IDX_OP      = 1;
  localparam int IDX_SRC1_HI = 2;
  localparam int IDX_SRC1_LO = 3;
  localparam int IDX_SRC2_HI = 4;
  localparam int IDX_SRC2_LO = 5;
  localparam int IDX_END     = 6;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_SEND = 1'b1
  } enc_state_t;

endpackage

// File: rtl/cmd_encoder_if.sv
// rtl/cmd_encoder_if.sv - command input and byte output handshake bundle for cmd_encoder
interface cmd_encoder_if;
  import cmd_proto_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [TYPE_W-1:0] data_type;
  logic [OP_W-1:0]   operator;
  logic [SRC_W-1:0]  src1;
  logic [SRC_W-1:0]  src2;
  logic [7:0]        data;
  logic              dout_valid;
  logic              dout_ready;
  logic              enc_done;

  modport master (
    output cmd_valid, data_type, operator, src1, src2, dout_ready,
    input  cmd_ready, data, dout_valid, enc_done
  );

  modport slave (
    input  cmd_valid, data_type, operator, src1, src2, dout_ready,
    output cmd_ready, data, dout_valid, enc_done
  );

endinterface

// File: rtl/cmd_encoder.sv
// rtl/cmd_encoder.sv - serialises one parallel command into a fixed-length byte frame
module cmd_encoder
  import cmd_proto_pkg::*;
#(
  parameter int         FRAME_LEN = 14,
  parameter logic [7:0] END_BYTE  = END_BYTE_VAL,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic          clk,
  input  logic          n_rst,
  cmd_encoder_if.slave  bus
);

  localparam int             CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  enc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              latch;

  logic [TYPE_W-1:0] type_q;
  logic [OP_W-1:0]   op_q;
  logic [SRC_W-1:0]  src1_q;
  logic [SRC_W-1:0]  src2_q;

  logic [CNT_W-1:0]  next_idx;
  logic [7:0]        next_byte;

  assign next_idx = count_q + CNT_W'(1);

  // Byte for the following position, taken from latched fields; b0 is loaded at accept.
  always_comb begin
    next_byte = PAD_BYTE;
    case (next_idx)
      CNT_W'(IDX_OP):      next_byte = {3'b000, op_q};
      CNT_W'(IDX_SRC1_HI): next_byte = src1_q[15:8];
      CNT_W'(IDX_SRC1_LO): next_byte = src1_q[7:0];
      CNT_W'(IDX_SRC2_HI): next_byte = src2_q[15:8];
      CNT_W'(IDX_SRC2_LO): next_byte = src2_q[7:0];
      CNT_W'(IDX_END):     next_byte = END_BYTE;
      default:             next_byte = PAD_BYTE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        if (bus.cmd_valid) begin
          latch   = 1'b1;
          count_d = '0;
          data_d  = {4'h0, bus.data_type};
          state_d = ENC_SEND;
        end
      end
      ENC_SEND: begin
        if (bus.dout_ready) begin
          if (count_q == LAST) begin
            state_d = ENC_IDLE;
            done_d  = 1'b1;
            data_d  = 8'h00;
          end else begin
            count_d = next_idx;
            data_d  = next_byte;
          end
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ENC_IDLE;
      count_q <= '0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      type_q <= '0;
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else if (latch) begin
      type_q <= bus.data_type;
      op_q   <= bus.operator;
      src1_q <= bus.src1;
      src2_q <= bus.src2;
    end
  end

  assign bus.cmd_ready  = (state_q == ENC_IDLE);
  assign bus.dout_valid = (state_q == ENC_SEND);
  assign bus.data       = data_q;
  assign bus.enc_done   = done_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// tb/tb_cmd_encoder.sv - scoreboard bench for cmd_encoder at FRAME_LEN 14 and 7
module tb_cmd_encoder;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  cmd_encoder_if b14();
  cmd_encoder_if b7();

  cmd_encoder #(.FRAME_LEN(14)) u14 (.clk(clk), .n_rst(n_rst), .bus(b14));
  cmd_encoder #(.FRAME_LEN(7))  u7  (.clk(clk), .n_rst(n_rst), .bus(b7));

  int checks = 0;
  int errors = 0;

  // bit 8 set marks the expected enc_done pulse after the last byte
  logic [8:0] q14[$];
  logic [8:0] q7[$];
  int xfer14 = 0;

  bit       tog = 1'b0;
  bit [3:0] pat = 4'b1001;
  int       pi  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  task automatic push_frame(input int sel, input logic [3:0] t, input logic [4:0] op,
                            input logic [15:0] s1, input logic [15:0] s2);
    logic [7:0] hdr[7];
    int len;
    hdr = '{{4'h0, t}, {3'b000, op}, s1[15:8], s1[7:0], s2[15:8], s2[7:0], 8'hBD};
    len = (sel == 14) ? 14 : 7;
    for (int i = 0; i < len; i++) begin
      if (sel == 14) q14.push_back({1'b0, (i < 7) ? hdr[i] : 8'h00});
      else           q7.push_back({1'b0, (i < 7) ? hdr[i] : 8'h00});
    end
    if (sel == 14) q14.push_back(9'h100);
    else           q7.push_back(9'h100);
  endtask

  task automatic set_fields(input int sel, input logic v, input logic [3:0] t,
                            input logic [4:0] op, input logic [15:0] s1, input logic [15:0] s2);
    if (sel == 14) begin
      b14.cmd_valid = v; b14.data_type = t; b14.operator = op; b14.src1 = s1; b14.src2 = s2;
    end else begin
      b7.cmd_valid = v; b7.data_type = t; b7.operator = op; b7.src1 = s1; b7.src2 = s2;
    end
  endtask

  task automatic send_cmd(input int sel, input logic [3:0] t, input logic [4:0] op,
                          input logic [15:0] s1, input logic [15:0] s2,
                          input bit keep, output bit in_done);
    bit acc = 1'b0;
    int n = 0;
    in_done = 1'b0;
    set_fields(sel, 1'b1, t, op, s1, s2);
    while (!acc && n < 200) begin
      @(negedge clk);
      if ((sel == 14) ? b14.cmd_ready : b7.cmd_ready) begin
        acc = 1'b1;
        in_done = (sel == 14) ? b14.enc_done : b7.enc_done;
        push_frame(sel, t, op, s1, s2);
      end
      n++;
    end
    if (!acc) fail_now("accept_timeout");
    @(posedge clk); #1;
    if (!keep) begin
      if (sel == 14) b14.cmd_valid = 1'b0;
      else           b7.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q14.size() != 0 || q7.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q14.size() != 0 || q7.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog) begin
        b14.dout_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else begin
        b14.dout_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] it;
    if (n_rst) begin
      if (b14.enc_done) begin
        if (q14.size() == 0) fail_now("done14_unexpected");
        else begin it = q14.pop_front(); chk("done14_order", {31'd0, it[8]}, 32'd1); end
      end
      if (b14.dout_valid) begin
        chk("ready14_busy", {31'd0, b14.cmd_ready}, 32'd0);
        if (q14.size() == 0) fail_now("byte14_unexpected");
        else if (b14.dout_ready) begin
          it = q14.pop_front();
          chk("byte14", {23'd0, it}, {24'd0, b14.data});
          xfer14++;
        end else begin
          chk("hold14", {23'd0, q14[0]}, {24'd0, b14.data});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] it;
    if (n_rst) begin
      if (b7.enc_done) begin
        if (q7.size() == 0) fail_now("done7_unexpected");
        else begin it = q7.pop_front(); chk("done7_order", {31'd0, it[8]}, 32'd1); end
      end
      if (b7.dout_valid && b7.dout_ready) begin
        if (q7.size() == 0) fail_now("byte7_unexpected");
        else begin it = q7.pop_front(); chk("byte7", {23'd0, it}, {24'd0, b7.data}); end
      end
    end
  end

  initial begin
    bit d;
    int run;
    int base;
    int n;
    set_fields(14, 1'b0, 4'h0, 5'h0, 16'h0, 16'h0);
    set_fields(7, 1'b0, 4'h0, 5'h0, 16'h0, 16'h0);
    b14.dout_ready = 1'b1;
    b7.dout_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_data",    {24'd0, b14.data}, 32'd0);
    chk("rst_valid",   {31'd0, b14.dout_valid}, 32'd0);
    chk("rst_done",    {31'd0, b14.enc_done}, 32'd0);
    chk("rst_ready",   {31'd0, b14.cmd_ready}, 32'd1);
    chk("rst_ready7",  {31'd0, b7.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // basic frame, ready tied high: 14 consecutive valid cycles
    send_cmd(14, 4'h3, 5'h02, 16'h1234, 16'hABCD, 1'b0, d);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (b14.dout_valid) run++;
    end
    chk("valid_run", run, 32'd14);
    wait_idle();

    // backpressure 1,0,0,1
    tog = 1'b1;
    send_cmd(14, 4'h3, 5'h02, 16'h1234, 16'hABCD, 1'b0, d);
    wait_idle();
    tog = 1'b0;
    @(posedge clk); #1;

    // cmd inputs changed and valid asserted mid-frame
    send_cmd(14, 4'h5, 5'h0A, 16'h5A5A, 16'h0F0F, 1'b0, d);
    set_fields(14, 1'b1, 4'hE, 5'h11, 16'hDEAD, 16'hBEEF);
    repeat (5) begin
      @(negedge clk);
      chk("midframe_ready", {31'd0, b14.cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    b14.cmd_valid = 1'b0;
    wait_idle();

    // back-to-back with cmd_valid held high
    send_cmd(14, 4'h3, 5'h02, 16'h1234, 16'hABCD, 1'b1, d);
    send_cmd(14, 4'h1, 5'h1F, 16'hFFFF, 16'h0000, 1'b0, d);
    chk("b2b_accept_in_done", {31'd0, d}, 32'd1);
    chk("b2b_b0_valid", {31'd0, b14.dout_valid}, 32'd1);
    chk("b2b_b0_data", {24'd0, b14.data}, 32'h01);
    wait_idle();

    // async reset after byte 3
    base = xfer14;
    send_cmd(14, 4'h7, 5'h09, 16'h4321, 16'h8765, 1'b0, d);
    n = 0;
    while (xfer14 < base + 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (xfer14 < base + 4) fail_now("xfer_timeout");
    @(posedge clk); #1;
    n_rst = 1'b0;
    q14.delete();
    q7.delete();
    #1;
    chk("midrst_valid", {31'd0, b14.dout_valid}, 32'd0);
    chk("midrst_ready", {31'd0, b14.cmd_ready}, 32'd1);
    chk("midrst_data",  {24'd0, b14.data}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    send_cmd(14, 4'hA, 5'h15, 16'hBEEF, 16'h0123, 1'b0, d);
    chk("post_rst_b0", {24'd0, b14.data}, 32'h0A);
    wait_idle();

    // short frame, no padding
    send_cmd(7, 4'h3, 5'h02, 16'h1234, 16'hABCD, 1'b0, d);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_idle14", {31'd0, b14.cmd_ready}, 32'd1);
    chk("final_idle7",  {31'd0, b7.cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_encoder.md
Name: cmd_encoder

Overview:
- Transmit-side packetiser for the command byte protocol consumed by the command decoder.
- Accepts one parallel command (data_type, operator, src1, src2) through a valid/ready handshake.
- Serialises it into a fixed-length byte frame on a data/dout_valid stream with backpressure.
- Sits between the command-generation logic and the byte link (UART/FIFO) that feeds the decoder.

Parameters:
- FRAME_LEN, 14, total bytes per frame. Must be >= 7; bytes 7..FRAME_LEN-1 are padding.
- END_BYTE, 8'hBD, end-of-protocol marker sent as byte 6.
- PAD_BYTE, 8'h00, value of each padding byte.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command fields valid.
- cmd_ready  output  1  encoder can accept a command.
- data_type  input  4  command format/type field.
- operator  input  5  operator code.
- src1  input  16  source operand 1.
- src2  input  16  source operand 2.
- data  output  8  current frame byte.
- dout_valid  output  1  data holds a valid byte.
- dout_ready  input  1  sink accepts the byte this cycle.
- enc_done  output  1  one-cycle pulse: frame fully sent.

Behaviour:
- Reset (async, n_rst low):
  - state=IDLE, byte counter=0, field registers=0.
  - data=0, dout_valid=0, enc_done=0, cmd_ready=1 (combinational from IDLE).
  - Takes effect immediately, including mid-frame. The partial frame is abandoned; no resume after release.
- Frame byte order:
  - b0={4'h0,data_type}
  - b1={3'b000,operator}
  - b2=src1[15:8]
  - b3=src1[7:0]
  - b4=src2[15:8]
  - b5=src2[7:0]
  - b6=END_BYTE
  - b7..b(FRAME_LEN-1)=PAD_BYTE
- Fields are latched on acceptance. Input changes mid-frame have no effect.
- States:
  - IDLE:
    - cmd_ready=1, dout_valid=0.
    - On the clk edge where cmd_valid=1: latch fields, count=0, go SEND.
    - In the next cycle data=b0 and dout_valid=1 (1-cycle latency from accept to first byte).
  - SEND:
    - cmd_ready=0. dout_valid=1. data=byte[count], driven from a register (no combinational path from dout_ready to data).
    - Byte transfer occurs on an edge where dout_valid&&dout_ready.
    - On transfer with count<FRAME_LEN-1: count+1; the next byte is presented the following cycle.
    - On transfer with count==FRAME_LEN-1: go IDLE, dout_valid=0 next cycle, enc_done=1 for exactly that one cycle.
    - dout_ready=0 holds data and count stable indefinitely. dout_valid never drops mid-frame.
- Throughput:
  - With dout_ready tied 1, one byte per clk: FRAME_LEN consecutive valid cycles.
  - Minimum of one IDLE cycle between frames: a new command is accepted in the enc_done cycle, and its b0 appears the cycle after. Minimum frame period is FRAME_LEN+1 cycles.
- cmd_valid while cmd_ready=0 is ignored; the upstream holds until accepted.
- Counter width is clog2(FRAME_LEN). No wrap other than the explicit return to IDLE.

Decomposition:
- Shared package cmd_proto_pkg (also used by the decoder):
  - END_BYTE value, field widths (type 4, operator 5, src 16).
  - Byte-index constants IDX_TYPE=0 .. IDX_END=6.
  - Encoder state enum.
- No sub-module required. Byte selection is a mux in the main block.

Test Plan:
- Reset then cmd type=4'h3, op=5'h02, src1=16'h1234, src2=16'hABCD, dout_ready=1 -> bytes 03,02,12,34,AB,CD,BD, then seven 00 on 14 consecutive cycles; enc_done pulses once after the last byte; cmd_ready=0 throughout.
- Same command with dout_ready toggling 1,0,0,1 pattern -> identical byte sequence, each byte held stable while ready=0, no duplicates or drops.
- Change cmd inputs and assert cmd_valid mid-frame -> ignored; frame still carries the latched values; cmd_ready=0.
- Two commands back-to-back with cmd_valid held high (second type=4'h1, op=5'h1F, src1=16'hFFFF, src2=16'h0000) -> second frame's b0=01 appears exactly one cycle after first enc_done; b1=1F.
- Assert n_rst low after byte 3 of a frame -> dout_valid=0 and cmd_ready=1 immediately; after release the next command starts cleanly at b0.
- FRAME_LEN=7 instance -> frame ends at BD, no padding, enc_done in the cycle after BD is accepted.
